i2c_bit_engine: RTL and testbench

- Bus-level I2C master engine, directly downstream of the I2C state controller.
- Executes one primitive command per handshake (start, repeat start, stop, send byte with ACK check, receive byte, send single '1') on open-drain SCL/SDA.
- Pulses req_next on normal completion, or ack_failed on a NACK, so the controller can advance its sequence.
- Single master. No clock stretching. No arbitration.

---
 rtl/i2c_bit_engine.sv | 155 +++++++++++++++
 tb/tb_i2c_bit_engine.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_bit_engine.sv
// i2c_bit_engine: executes one I2C bus primitive per command handshake on open-drain SCL/SDA
module i2c_bit_engine #(
   parameter int CLK_DIV = 250
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] cmd,
   input  logic [7:0] cmd_byte,
   output logic       req_next,
   output logic       ack_failed,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       sda_in
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
   localparam logic [2:0] C_START  = 3'd1;
   localparam logic [2:0] C_RSTART = 3'd3;
   localparam logic [2:0] C_STOP   = 3'd4;
   localparam logic [2:0] C_SEND   = 3'd5;
   localparam logic [2:0] C_RECV   = 3'd6;
   localparam logic [7:0] T_START  = 8'b11_01_00_00;
   localparam logic [7:0] T_RSTART = 8'b11_01_00_10;
   localparam logic [7:0] T_STOP   = 8'b00_00_01_11;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    phase_q, phase_d;
   logic [3:0]    bit_q, bit_d;
   logic [2:0]    cmd_q, cmd_d;
   logic [7:0]    byte_q, byte_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          ack_q, ack_d;
   logic          scl_q, scl_d;
   logic          sda_q, sda_d;
   logic          req_q, req_d;
   logic          ackf_q, ackf_d;
   logic          rxv_q, rxv_d;
   logic          sync1_q, sync2_q;
   logic          accept, tick, last;

   // {scl_oe, sda_oe} for phase p of bit n; tables hold Q3..Q0 as 2-bit pairs
   function automatic logic [1:0] phase_lines(input logic [2:0] c, input logic [7:0] b,
                                              input logic [3:0] n, input logic [1:0] p);
      logic       d;
      logic [7:0] t;
      d = (c == C_SEND && n < 4'd8) ? b[3'd7 - n[2:0]] : 1'b1;
      t = (c == C_START) ? T_START : (c == C_RSTART) ? T_RSTART : T_STOP;
      phase_lines = (c == C_START || c == C_RSTART || c == C_STOP) ? t[{p, 1'b0} +: 2]
                                                                   : {p == 2'd0 || p == 2'd3, ~d};
   endfunction

   // state register, divider, shifters and registered outputs
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         phase_q   <= '0;
         bit_q     <= '0;
         cmd_q     <= '0;
         byte_q    <= '0;
         shift_q   <= '0;
         rx_data_q <= '0;
         ack_q     <= 1'b0;
         scl_q     <= 1'b0;
         sda_q     <= 1'b0;
         req_q     <= 1'b0;
         ackf_q    <= 1'b0;
         rxv_q     <= 1'b0;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         cmd_q     <= cmd_d;
         byte_q    <= byte_d;
         shift_q   <= shift_d;
         rx_data_q <= rx_data_d;
         ack_q     <= ack_d;
         scl_q     <= scl_d;
         sda_q     <= sda_d;
         req_q     <= req_d;
         ackf_q    <= ackf_d;
         rxv_q     <= rxv_d;
         sync1_q   <= sda_in;
         sync2_q   <= sync1_q;
      end
   end

   // command acceptance, phase sequencing, SDA sampling and completion pulses
   always_comb begin
      accept    = reset && state_q == IDLE && cmd != 3'd0 && cmd != 3'd7;
      tick      = state_q == RUN && cnt_q == CNT_MAX;
      last      = phase_q == 2'd3 &&
                  bit_q == ((cmd_q == C_SEND) ? 4'd8 : (cmd_q == C_RECV) ? 4'd7 : 4'd0);
      state_d   = state_q;
      cnt_d     = cnt_q;
      phase_d   = phase_q;
      bit_d     = bit_q;
      cmd_d     = cmd_q;
      byte_d    = byte_q;
      shift_d   = shift_q;
      rx_data_d = rx_data_q;
      ack_d     = ack_q;
      scl_d     = scl_q;
      sda_d     = sda_q;
      req_d     = 1'b0;
      ackf_d    = 1'b0;
      rxv_d     = 1'b0;
      if (accept) begin
         state_d        = RUN;
         cnt_d          = '0;
         phase_d        = 2'd0;
         bit_d          = 4'd0;
         cmd_d          = cmd;
         byte_d         = cmd_byte;
         {scl_d, sda_d} = phase_lines(cmd, cmd_byte, 4'd0, 2'd0);
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end else if (state_q == RUN) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
         if (tick && phase_q == 2'd2) begin
            shift_d = {shift_q[6:0], sync2_q};
            ack_d   = sync2_q;
         end
         if (tick && last) begin
            state_d   = DONE;
            ackf_d    = cmd_q == C_SEND && ack_q;
            req_d     = !(cmd_q == C_SEND && ack_q);
            rxv_d     = cmd_q == C_RECV;
            rx_data_d = (cmd_q == C_RECV) ? shift_q : rx_data_q;
         end else if (tick) begin
            phase_d        = phase_q + 2'd1;
            bit_d          = (phase_q == 2'd3) ? bit_q + 4'd1 : bit_q;
            {scl_d, sda_d} = phase_lines(cmd_q, byte_q, bit_d, phase_d);
         end
      end
   end

   assign busy       = accept || state_q != IDLE;
   assign req_next   = req_q;
   assign ack_failed = ackf_q;
   assign rx_valid   = rxv_q;
   assign rx_data    = rx_data_q;
   assign scl_oe     = scl_q;
   assign sda_oe     = sda_q;
endmodule

// File: tb/tb_i2c_bit_engine.sv
// tb_i2c_bit_engine: directed checks of the I2C bit engine against hand-computed bus timing
module tb_i2c_bit_engine;
   localparam int D = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] cmd = 3'd0;
   logic [7:0] cmd_byte = 8'h00;
   logic       sda_in = 1'b1;
   logic       req_next, ack_failed, rx_valid, busy, scl_oe, sda_oe;
   logic [7:0] rx_data;

   int         n_checks = 0;
   int         n_fail = 0;
   int         req_at, req_cnt, ackf_at, ackf_cnt, rxv_at, busy_last;
   int         sda_first, scl_first, sda_last, scl_last, cnt;
   logic       busy_a, scl_at_sda_first, sda_ever;
   logic [7:0] rxd;
   logic [8:0] sda_rel, scl_mid;

   i2c_bit_engine #(.CLK_DIV(D)) dut (
      .clock(clock), .reset(reset), .cmd(cmd), .cmd_byte(cmd_byte),
      .req_next(req_next), .ack_failed(ack_failed), .rx_data(rx_data), .rx_valid(rx_valid),
      .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // present one command at cycle A, then observe cycles A+1..A+4*nbits*D+3 at the falling edge;
   // the slave model drives slave_bits MSB first, one bit per SCL period starting with Q0
   task automatic run_cmd(input logic [2:0] c, input logic [7:0] b, input logic [8:0] slave_bits,
                          input int nbits);
      int bi, o;
      req_at = -1; ackf_at = -1; rxv_at = -1; req_cnt = 0; ackf_cnt = 0; busy_last = -1;
      sda_first = -1; scl_first = -1; sda_last = -1; scl_last = -1;
      sda_ever = 1'b0; scl_at_sda_first = 1'b1; rxd = 8'h00; sda_rel = '0; scl_mid = '1;
      @(negedge clock);
      cmd = c;
      cmd_byte = b;
      #1 busy_a = busy;
      for (int k = 1; k <= 4 * nbits * D + 3; k++) begin
         @(negedge clock);
         cmd = 3'd0;
         cmd_byte = ~b;
         bi = (k - 1) / (4 * D);
         o = (k - 1) % (4 * D);
         if (req_next) begin req_cnt++; if (req_at < 0) req_at = k; end
         if (ack_failed) begin ackf_cnt++; if (ackf_at < 0) ackf_at = k; end
         if (rx_valid) begin rxv_at = k; rxd = rx_data; end
         if (busy) busy_last = k;
         if (sda_oe) begin
            sda_ever = 1'b1;
            sda_last = k;
            if (sda_first < 0) begin sda_first = k; scl_at_sda_first = scl_oe; end
         end
         if (scl_oe) begin scl_last = k; if (scl_first < 0) scl_first = k; end
         if (o == 2 * D - 1 && bi < 9) begin sda_rel[8-bi] = ~sda_oe; scl_mid[8-bi] = scl_oe; end
         sda_in = (bi < 9) ? slave_bits[8-bi] : 1'b1;
      end
   endtask

   initial begin
      // power-on reset
      repeat (3) @(negedge clock);
      check("rst_scl", 32'(scl_oe), 0);
      check("rst_sda", 32'(sda_oe), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_pulses", 32'({req_next, ack_failed, rx_valid}), 0);
      check("rst_rxdata", 32'(rx_data), 32'h00);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // start
      run_cmd(3'd1, 8'h00, 9'h1FF, 1);
      check("start_busy_A", 32'(busy_a), 1);
      check("start_sda_first", sda_first, 9);
      check("start_scl_at_sda", 32'(scl_at_sda_first), 0);
      check("start_scl_first", scl_first, 13);
      check("start_req_at", req_at, 17);
      check("start_req_cnt", req_cnt, 1);
      check("start_busy_last", busy_last, 17);
      check("start_lines", 32'({scl_oe, sda_oe}), 32'b11);

      // send 0xA6, acked
      run_cmd(3'd5, 8'hA6, {8'hFF, 1'b0}, 9);
      check("send_pattern", 32'(sda_rel), 32'h14D);
      check("send_scl_mid", 32'(scl_mid), 0);
      check("send_req_at", req_at, 145);
      check("send_req_cnt", req_cnt, 1);
      check("send_ackf_cnt", ackf_cnt, 0);
      check("send_busy_last", busy_last, 145);

      // send 0xA6, nacked
      run_cmd(3'd5, 8'hA6, {8'hFF, 1'b1}, 9);
      check("nack_ackf_at", ackf_at, 145);
      check("nack_ackf_cnt", ackf_cnt, 1);
      check("nack_req_cnt", req_cnt, 0);

      // receive 0x3C
      run_cmd(3'd6, 8'h00, {8'h3C, 1'b1}, 8);
      check("recv_sda_never", 32'(sda_ever), 0);
      check("recv_rxv_at", rxv_at, 129);
      check("recv_data", 32'(rxd), 32'h3C);
      check("recv_req_at", req_at, 129);
      check("recv_req_cnt", req_cnt, 1);
      check("recv_ackf_cnt", ackf_cnt, 0);

      // send_one (NACK after receive)
      run_cmd(3'd2, 8'h00, 9'h1FF, 1);
      check("one_sda_never", 32'(sda_ever), 0);
      check("one_scl_mid", 32'(scl_mid[8]), 0);
      check("one_req_at", req_at, 17);

      // repeat start
      run_cmd(3'd3, 8'h00, 9'h1FF, 1);
      check("rs_sda_first", sda_first, 9);
      check("rs_scl_at_sda", 32'(scl_at_sda_first), 0);
      check("rs_scl_first", scl_first, 1);
      check("rs_req_at", req_at, 17);
      check("rs_lines", 32'({scl_oe, sda_oe}), 32'b11);

      // stop
      run_cmd(3'd4, 8'h00, 9'h1FF, 1);
      check("stop_scl_last", scl_last, 4);
      check("stop_sda_last", sda_last, 8);
      check("stop_req_at", req_at, 17);
      check("stop_lines", 32'({scl_oe, sda_oe}), 0);

      // reset while a send_byte is in progress
      @(negedge clock);
      cmd = 3'd5;
      cmd_byte = 8'hA6;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock);
         cmd = 3'd0;
      end
      check("abort_pre_lines", 32'({scl_oe, sda_oe}), 32'b11);
      reset = 1'b0;
      @(negedge clock);
      check("abort_lines", 32'({scl_oe, sda_oe}), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_req", 32'(req_next), 0);
      @(negedge clock);
      reset = 1'b1;
      cnt = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clock);
         if (req_next || ack_failed || busy || scl_oe || sda_oe) cnt++;
      end
      check("abort_quiet", cnt, 0);

      // write transaction: START, 0xA4, 0x10, 0x55 (all acked), STOP
      run_cmd(3'd1, 8'h00, 9'h1FF, 1);
      check("seq_start_req", req_at, 17);
      run_cmd(3'd5, 8'hA4, {8'hFF, 1'b0}, 9);
      check("seq_a4_pattern", 32'(sda_rel), 32'h149);
      check("seq_a4_req", req_at, 145);
      check("seq_a4_ackf", ackf_cnt, 0);
      run_cmd(3'd5, 8'h10, {8'hFF, 1'b0}, 9);
      check("seq_10_pattern", 32'(sda_rel), 32'h021);
      check("seq_10_req", req_at, 145);
      run_cmd(3'd5, 8'h55, {8'hFF, 1'b0}, 9);
      check("seq_55_pattern", 32'(sda_rel), 32'h0AB);
      check("seq_55_req", req_at, 145);
      run_cmd(3'd4, 8'h00, 9'h1FF, 1);
      check("seq_stop_req", req_at, 17);
      check("seq_bus_released", 32'({scl_oe, sda_oe}), 0);
      cnt = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clock);
         if (req_next || ack_failed || busy || scl_oe || sda_oe) cnt++;
      end
      check("seq_idle_quiet", cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
